// File: rtl/tc_operand_collector_if.sv
// ----------------------------------------------------------------------------
// tc_operand_collector_if
// Bundles every bus that the operand collector exchanges with its neighbours.
//   req_*        : MMA request handshake and base register rows (requester -> collector)
//   rf_rd_*      : single register-file read port (collector <-> register file)
//   tc_matrix_*  : packed 4x4 BF16 operand buses to the tensor core
//   tc_valid_in  : start pulse to the tensor core
//   tc_valid_out : completion pulse from the tensor core
//   done_*       : completion report with the request tag
// Modport slave is the collector's view; master is the surrounding system's.
// ----------------------------------------------------------------------------
interface tc_operand_collector_if #(
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_a_base;
    logic [ADDR_W-1:0] req_b_base;
    logic [ADDR_W-1:0] req_c_base;
    logic [TAG_W-1:0]  req_tag;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_rd_addr;
    logic [63:0]       rf_rd_data;
    logic [255:0]      tc_matrix_a;
    logic [255:0]      tc_matrix_b;
    logic [255:0]      tc_matrix_c;
    logic              tc_valid_in;
    logic              tc_valid_out;
    logic              done_valid;
    logic [TAG_W-1:0]  done_tag;

    modport slave (
        input  req_valid, req_a_base, req_b_base, req_c_base, req_tag,
        output req_ready,
        output rf_rd_en, rf_rd_addr,
        input  rf_rd_data,
        output tc_matrix_a, tc_matrix_b, tc_matrix_c, tc_valid_in,
        input  tc_valid_out,
        output done_valid, done_tag
    );

    modport master (
        output req_valid, req_a_base, req_b_base, req_c_base, req_tag,
        input  req_ready,
        input  rf_rd_en, rf_rd_addr,
        output rf_rd_data,
        input  tc_matrix_a, tc_matrix_b, tc_matrix_c, tc_valid_in,
        output tc_valid_out,
        input  done_valid, done_tag
    );
endinterface

// File: rtl/tc_operand_collector.sv
// ----------------------------------------------------------------------------
// tc_operand_collector
// Accepts one MMA request (A/B/C base rows + tag), reads the 12 operand rows
// through one register-file read port, packs them into the 256-bit A/B/C
// buses, starts the tensor core with a one-cycle pulse and reports completion
// with the request tag once the core answers.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tc_operand_collector_if.slave (request, register-file port,
//           tensor-core operands/handshake, completion report)
// ----------------------------------------------------------------------------
module tc_operand_collector #(
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tc_operand_collector_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        FIRE = 3'd3,
        WAIT = 3'd4
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] a_base_r;
    logic [ADDR_W-1:0] b_base_r;
    logic [ADDR_W-1:0] c_base_r;
    logic [TAG_W-1:0]  tag_r;
    logic [3:0]        cnt_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    // Read data returns one cycle after the strobe, so the capture side
    // works from a one-cycle delayed copy of the strobe and row counter.
    logic              cap_en_r;
    logic [3:0]        cap_cnt_r;
    logic [255:0]      mat_a_r;
    logic [255:0]      mat_b_r;
    logic [255:0]      mat_c_r;
    logic              valid_in_r;
    logic              done_valid_r;
    logic [TAG_W-1:0]  done_tag_r;

    logic [3:0]        next_cnt_s;
    logic [ADDR_W-1:0] next_base_s;
    logic [ADDR_W-1:0] next_addr_s;

    // Row address for the following READ cycle: group base plus row offset,
    // wrapping naturally at the address width.
    always_comb begin
        next_cnt_s  = cnt_r + 4'd1;
        next_base_s = c_base_r;
        case (next_cnt_s[3:2])
            2'd0:    next_base_s = a_base_r;
            2'd1:    next_base_s = b_base_r;
            2'd2:    next_base_s = c_base_r;
            default: next_base_s = c_base_r;
        endcase
        next_addr_s = next_base_s + ADDR_W'(next_cnt_s[1:0]);
    end

    // Main sequencer: request latch, read burst, row capture, start pulse,
    // completion wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            a_base_r     <= '0;
            b_base_r     <= '0;
            c_base_r     <= '0;
            tag_r        <= '0;
            cnt_r        <= 4'd0;
            rd_en_r      <= 1'b0;
            rd_addr_r    <= '0;
            cap_en_r     <= 1'b0;
            cap_cnt_r    <= 4'd0;
            mat_a_r      <= 256'd0;
            mat_b_r      <= 256'd0;
            mat_c_r      <= 256'd0;
            valid_in_r   <= 1'b0;
            done_valid_r <= 1'b0;
            done_tag_r   <= '0;
        end else begin
            cap_en_r     <= rd_en_r;
            cap_cnt_r    <= cnt_r;
            valid_in_r   <= 1'b0;
            done_valid_r <= 1'b0;

            if (cap_en_r) begin
                case (cap_cnt_r[3:2])
                    2'd0:    mat_a_r[{cap_cnt_r[1:0], 6'd0} +: 64] <= bus.rf_rd_data;
                    2'd1:    mat_b_r[{cap_cnt_r[1:0], 6'd0} +: 64] <= bus.rf_rd_data;
                    2'd2:    mat_c_r[{cap_cnt_r[1:0], 6'd0} +: 64] <= bus.rf_rd_data;
                    default: mat_c_r <= mat_c_r;
                endcase
            end else begin
                mat_a_r <= mat_a_r;
            end

            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_base_r  <= bus.req_a_base;
                        b_base_r  <= bus.req_b_base;
                        c_base_r  <= bus.req_c_base;
                        tag_r     <= bus.req_tag;
                        cnt_r     <= 4'd0;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= bus.req_a_base;
                        state_r   <= READ;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                READ: begin
                    cnt_r <= next_cnt_s;
                    if (cnt_r == 4'd11) begin
                        // Address register keeps its last value once the strobe drops.
                        rd_en_r <= 1'b0;
                        state_r <= CAPT;
                    end else begin
                        rd_addr_r <= next_addr_s;
                    end
                end
                CAPT: begin
                    valid_in_r <= 1'b1;
                    state_r    <= FIRE;
                end
                FIRE: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (bus.tc_valid_out) begin
                        done_valid_r <= 1'b1;
                        done_tag_r   <= tag_r;
                        state_r      <= IDLE;
                    end else begin
                        state_r      <= WAIT;
                    end
                end
                default: begin
                    rd_en_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_r == IDLE);
    assign bus.rf_rd_en    = rd_en_r;
    assign bus.rf_rd_addr  = rd_addr_r;
    assign bus.tc_matrix_a = mat_a_r;
    assign bus.tc_matrix_b = mat_b_r;
    assign bus.tc_matrix_c = mat_c_r;
    assign bus.tc_valid_in = valid_in_r;
    assign bus.done_valid  = done_valid_r;
    assign bus.done_tag    = done_tag_r;

endmodule

// File: tb/tb_tc_operand_collector.sv
// ----------------------------------------------------------------------------
// tb_tc_operand_collector
// Self-checking bench: a table of directed requests, hand-written sequences
// for backpressure, spurious completions and reset mid-read, then randomized
// requests compared with a register-file based reference model.
// ----------------------------------------------------------------------------
module tb_tc_operand_collector;

    localparam int AW = 5;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tc_operand_collector_if #(.ADDR_W(AW), .TAG_W(TW)) bus ();

    tc_operand_collector #(.ADDR_W(AW), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [63:0] rf [0:31];

    // Register file: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        bus.rf_rd_data <= bus.rf_rd_en ? rf[bus.rf_rd_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]      a;
        logic [4:0]      b;
        logic [4:0]      c;
        logic [3:0]      tag;
        int              wait_cyc;
        bit              spur;
        bit              has_exp;
        logic [3:0][4:0] exp_a;     // first four read addresses, entry 0 first
        bit              alias_chk;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // k-th read of a request: group base plus row index, modulo 32.
    function automatic logic [4:0] exp_addr(input vec_t v, input int k);
        int base;
        base = (k < 4) ? int'(v.a) : ((k < 8) ? int'(v.b) : int'(v.c));
        return 5'((base + (k % 4)) % 32);
    endfunction

    // Matrix built from four consecutive register rows starting at base.
    function automatic logic [255:0] exp_mat(input logic [4:0] base);
        logic [255:0] m;
        for (int r = 0; r < 4; r++) m[r*64 +: 64] = rf[(int'(base) + r) % 32];
        return m;
    endfunction

    task automatic drive_req(input vec_t v, input logic valid);
        bus.req_a_base = v.a;
        bus.req_b_base = v.b;
        bus.req_c_base = v.c;
        bus.req_tag    = v.tag;
        bus.req_valid  = valid;
    endtask

    // Cycles 1.. of a request already handshaken in the previous cycle.
    // With hold set, the next request nv is presented from cycle 1 on and is
    // accepted in the done cycle, where this task returns.
    task automatic run_body(input vec_t v, input bit hold, input vec_t nv);
        logic [255:0] ea, eb, ec;
        ea = exp_mat(v.a);
        eb = exp_mat(v.b);
        ec = exp_mat(v.c);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 1) drive_req(nv, hold);
            if (v.spur) bus.tc_valid_out = (cyc == 3);
            chk("ready_busy", bus.req_ready, 1'b0);
            chk("rd_en", bus.rf_rd_en, (cyc <= 12));
            if (cyc <= 12) chk("rd_addr", bus.rf_rd_addr, exp_addr(v, cyc - 1));
            if (v.has_exp && cyc <= 4) chk("a_addr_tbl", bus.rf_rd_addr, v.exp_a[cyc-1]);
            chk("valid_in", bus.tc_valid_in, (cyc == 14));
            chk("no_done", bus.done_valid, 1'b0);
        end
        chk("mat_a", bus.tc_matrix_a, ea);
        chk("mat_b", bus.tc_matrix_b, eb);
        chk("mat_c", bus.tc_matrix_c, ec);
        if (v.alias_chk) begin
            chk("alias_ab", bus.tc_matrix_b, bus.tc_matrix_a);
            chk("alias_ac", bus.tc_matrix_c, bus.tc_matrix_a);
        end
        for (int w = 0; w < v.wait_cyc; w++) begin
            @(negedge clk);
            chk("wait_ready", bus.req_ready, 1'b0);
            chk("wait_rd_en", bus.rf_rd_en, 1'b0);
            chk("wait_valid_in", bus.tc_valid_in, 1'b0);
            chk("wait_done", bus.done_valid, 1'b0);
        end
        @(negedge clk);
        bus.tc_valid_out = 1'b1;
        chk("pulse_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        bus.tc_valid_out = 1'b0;
        chk("done_valid", bus.done_valid, 1'b1);
        chk("done_tag", bus.done_tag, v.tag);
        chk("done_ready", bus.req_ready, 1'b1);
        chk("hold_a", bus.tc_matrix_a, ea);
        chk("hold_c", bus.tc_matrix_c, ec);
        if (!hold) begin
            @(negedge clk);
            chk("done_drop", bus.done_valid, 1'b0);
            chk("idle_ready", bus.req_ready, 1'b1);
        end
    endtask

    task automatic do_req(input vec_t v);
        int n;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", bus.req_ready, 1'b1);
        drive_req(v, 1'b1);
        run_body(v, 1'b0, v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1, v2, vr;
        bit bad;

        for (int k = 0; k < 32; k++)
            rf[k] = {16'(k*4+3), 16'(k*4+2), 16'(k*4+1), 16'(k*4)};

        tbl[0] = '{a:5'd0,  b:5'd4,  c:5'd8,  tag:4'd5,  wait_cyc:3, spur:1'b0, has_exp:1'b1,
                   exp_a:{5'd3, 5'd2, 5'd1, 5'd0},   alias_chk:1'b0};
        tbl[1] = '{a:5'd30, b:5'd12, c:5'd20, tag:4'd9,  wait_cyc:0, spur:1'b0, has_exp:1'b1,
                   exp_a:{5'd1, 5'd0, 5'd31, 5'd30}, alias_chk:1'b0};
        tbl[2] = '{a:5'd3,  b:5'd3,  c:5'd3,  tag:4'd2,  wait_cyc:1, spur:1'b0, has_exp:1'b1,
                   exp_a:{5'd6, 5'd5, 5'd4, 5'd3},   alias_chk:1'b1};
        tbl[3] = '{a:5'd29, b:5'd31, c:5'd17, tag:4'd15, wait_cyc:5, spur:1'b1, has_exp:1'b1,
                   exp_a:{5'd0, 5'd31, 5'd30, 5'd29}, alias_chk:1'b0};

        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_a_base   = 5'd0;
        bus.req_b_base   = 5'd0;
        bus.req_c_base   = 5'd0;
        bus.req_tag      = 4'd0;
        bus.tc_valid_out = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_rd_en", bus.rf_rd_en, 1'b0);
        chk("rst_rd_addr", bus.rf_rd_addr, 5'd0);
        chk("rst_mat_a", bus.tc_matrix_a, 256'd0);
        chk("rst_valid_in", bus.tc_valid_in, 1'b0);
        chk("rst_done", bus.done_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 4; i++) begin
            do_req(tbl[i]);
            if (i == 0) begin
                chk("a_elem_1_2", bus.tc_matrix_a[(1*4+2)*16 +: 16], 16'd6);
                chk("b_elem_0_0", bus.tc_matrix_b[0 +: 16], 16'd16);
                chk("c_elem_3_3", bus.tc_matrix_c[(3*4+3)*16 +: 16], 16'd47);
            end
        end

        // Spurious completion while idle.
        bus.tc_valid_out = 1'b1;
        @(negedge clk);
        bus.tc_valid_out = 1'b0;
        chk("spur_idle_done", bus.done_valid, 1'b0);
        chk("spur_idle_ready", bus.req_ready, 1'b1);

        // Backpressure: second request held through a long WAIT.
        v1 = '{a:5'd7, b:5'd14, c:5'd21, tag:4'd1, wait_cyc:35, spur:1'b0, has_exp:1'b0,
               exp_a:20'd0, alias_chk:1'b0};
        v2 = '{a:5'd16, b:5'd24, c:5'd28, tag:4'd7, wait_cyc:2, spur:1'b0, has_exp:1'b0,
               exp_a:20'd0, alias_chk:1'b0};
        drive_req(v1, 1'b1);
        chk("bp_ready", bus.req_ready, 1'b1);
        run_body(v1, 1'b1, v2);
        run_body(v2, 1'b0, v2);

        // Reset in the middle of the read burst (cycle 6).
        v1 = '{a:5'd10, b:5'd2, c:5'd20, tag:4'd11, wait_cyc:0, spur:1'b0, has_exp:1'b0,
               exp_a:20'd0, alias_chk:1'b0};
        drive_req(v1, 1'b1);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        chk("mid_rd_en", bus.rf_rd_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", bus.req_ready, 1'b1);
        chk("arst_rd_en", bus.rf_rd_en, 1'b0);
        chk("arst_rd_addr", bus.rf_rd_addr, 5'd0);
        chk("arst_mat_a", bus.tc_matrix_a, 256'd0);
        chk("arst_mat_b", bus.tc_matrix_b, 256'd0);
        chk("arst_mat_c", bus.tc_matrix_c, 256'd0);
        chk("arst_valid_in", bus.tc_valid_in, 1'b0);
        chk("arst_done", bus.done_valid, 1'b0);
        chk("arst_done_tag", bus.done_tag, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.tc_valid_in || bus.done_valid || bus.rf_rd_en) bad = 1'b1;
        end
        chk("aborted_quiet", bad, 1'b0);
        do_req(tbl[0]);

        // Randomized requests against the model.
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 32; k++) rf[k] = {$urandom, $urandom};
            vr.a         = 5'($urandom_range(0, 31));
            vr.b         = 5'($urandom_range(0, 31));
            vr.c         = 5'($urandom_range(0, 31));
            vr.tag       = 4'($urandom_range(0, 15));
            vr.wait_cyc  = $urandom_range(0, 6);
            vr.spur      = 1'($urandom_range(0, 1));
            vr.has_exp   = 1'b0;
            vr.exp_a     = 20'd0;
            vr.alias_chk = 1'b0;
            do_req(vr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
